// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the serial bus slave port.
package bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACKA,
    WDATA,
    WSTB,
    ACKW,
    RSTB,
    RWAIT,
    RDATA
  } state_t;

  localparam int BUS_ADDR_BITS = 16;
  localparam int DEV_SEL_BITS  = 2;
  localparam int DATA_BITS     = 8;

endpackage

// File: rtl/bus_slave_port_if.sv
// rtl/bus_slave_port_if.sv - serial bus signals between master and one slave port.
interface bus_slave_port_if;

  logic S_SEL;
  logic B_UTIL;
  logic B_RW;
  logic B_BUS_IN;
  logic B_BUS_OUT;
  logic B_ACK;
  logic B_READY;

  modport master (
    output S_SEL, B_UTIL, B_RW, B_BUS_IN,
    input  B_BUS_OUT, B_ACK, B_READY
  );

  modport slave (
    input  S_SEL, B_UTIL, B_RW, B_BUS_IN,
    output B_BUS_OUT, B_ACK, B_READY
  );

endinterface

// File: rtl/bus_slave_port_counter.sv
// rtl/bus_slave_port_counter.sv - up counter with synchronous clear and increment enable.
module bus_slave_port_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             rst,
  input  logic             incr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (rst) begin
      count_d = '0;
    end else if (incr) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bus_slave_port.sv
// rtl/bus_slave_port.sv - bit-serial bus slave: deserialises address/write data,
// strobes a local register port and serialises read data back, LSB first.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = DATA_BITS,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RSTN,
  bus_slave_port_if.slave   bus,
  output logic [ADDR_W-1:0] L_ADDR,
  output logic [DATA_W-1:0] L_WDATA,
  output logic              L_WEN,
  output logic              L_REN,
  input  logic [DATA_W-1:0] L_RDATA,
  input  logic              L_RVALID,
  input  logic              L_READY
);

  localparam int TO_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [3:0] ADDR_LO   = 4'(DEV_SEL_BITS);
  localparam logic [3:0] ADDR_HI   = 4'(DEV_SEL_BITS + ADDR_W - 1);
  localparam logic [3:0] ADDR_LAST = 4'(BUS_ADDR_BITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_W-2:0] wdata_sr_q, wdata_sr_d;
  logic [DATA_W-1:0] rdata_sr_q, rdata_sr_d;
  logic [ADDR_W-1:0] l_addr_q, l_addr_d;
  logic [DATA_W-1:0] l_wdata_q, l_wdata_d;
  logic              l_wen_q, l_wen_d;
  logic              l_ren_q, l_ren_d;
  logic              acka_q, acka_d;
  logic              ackw_q, ackw_d;
  logic              rd_active_q, rd_active_d;

  logic [DATA_W-1:0] wdata_full;
  logic [3:0]        bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              bit_rst, bit_incr, to_rst, to_incr;

  bus_slave_port_counter #(.WIDTH(4)) u_bit_cnt (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .rst   (bit_rst),
    .incr  (bit_incr),
    .count (bit_cnt)
  );

  bus_slave_port_counter #(.WIDTH(TO_W)) u_to_cnt (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .rst   (to_rst),
    .incr  (to_incr),
    .count (to_cnt)
  );

  always_comb begin
    state_d     = state_q;
    addr_sr_d   = addr_sr_q;
    wdata_sr_d  = wdata_sr_q;
    rdata_sr_d  = rdata_sr_q;
    l_addr_d    = l_addr_q;
    l_wdata_d   = l_wdata_q;
    l_wen_d     = 1'b0;
    l_ren_d     = 1'b0;
    acka_d      = 1'b0;
    ackw_d      = 1'b0;
    rd_active_d = 1'b0;
    bit_rst     = 1'b0;
    bit_incr    = 1'b0;
    to_rst      = 1'b1;
    to_incr     = 1'b0;
    wdata_full  = {bus.B_BUS_IN, wdata_sr_q};

    unique case (state_q)
      IDLE: begin
        // The selecting cycle already carries address bit 0.
        if (bus.B_UTIL && bus.S_SEL) begin
          state_d  = ADDR;
          bit_incr = 1'b1;
        end else begin
          bit_rst = 1'b1;
        end
      end
      ADDR: begin
        if (!bus.B_UTIL) begin
          state_d = IDLE;
          bit_rst = 1'b1;
        end else begin
          if (bit_cnt >= ADDR_LO && bit_cnt <= ADDR_HI) begin
            addr_sr_d = {bus.B_BUS_IN, addr_sr_q[ADDR_W-1:1]};
          end
          if (bit_cnt == ADDR_LAST) begin
            l_addr_d = addr_sr_q;
            acka_d   = 1'b1;
            state_d  = ACKA;
            bit_rst  = 1'b1;
          end else begin
            bit_incr = 1'b1;
          end
        end
      end
      ACKA: begin
        bit_rst = 1'b1;
        if (!L_READY) begin
          state_d = IDLE;
        end else if (bus.B_RW) begin
          state_d = WDATA;
        end else begin
          state_d = RSTB;
          l_ren_d = 1'b1;
        end
      end
      WDATA: begin
        if (!bus.B_UTIL) begin
          state_d = IDLE;
          bit_rst = 1'b1;
        end else if (bit_cnt == DATA_LAST) begin
          l_wdata_d = wdata_full;
          l_wen_d   = 1'b1;
          state_d   = WSTB;
          bit_rst   = 1'b1;
        end else begin
          wdata_sr_d = wdata_full[DATA_W-1:1];
          bit_incr   = 1'b1;
        end
      end
      WSTB: begin
        ackw_d  = 1'b1;
        state_d = ACKW;
        bit_rst = 1'b1;
      end
      ACKW: begin
        state_d = IDLE;
        bit_rst = 1'b1;
      end
      RSTB: begin
        state_d = RWAIT;
        bit_rst = 1'b1;
      end
      RWAIT: begin
        bit_rst = 1'b1;
        to_rst  = 1'b0;
        // Data arriving on the final timeout cycle is still taken.
        if (L_RVALID) begin
          rdata_sr_d  = L_RDATA;
          rd_active_d = 1'b1;
          state_d     = RDATA;
        end else if (to_cnt == TO_LAST) begin
          state_d = IDLE;
        end else begin
          to_incr = 1'b1;
        end
      end
      RDATA: begin
        rd_active_d = 1'b1;
        if (bus.B_UTIL) begin
          rdata_sr_d = rdata_sr_q >> 1;
          if (bit_cnt == DATA_LAST) begin
            rd_active_d = 1'b0;
            state_d     = IDLE;
            bit_rst     = 1'b1;
          end else begin
            bit_incr = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        bit_rst = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      addr_sr_q   <= '0;
      wdata_sr_q  <= '0;
      rdata_sr_q  <= '0;
      l_addr_q    <= '0;
      l_wdata_q   <= '0;
      l_wen_q     <= 1'b0;
      l_ren_q     <= 1'b0;
      acka_q      <= 1'b0;
      ackw_q      <= 1'b0;
      rd_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_sr_q   <= addr_sr_d;
      wdata_sr_q  <= wdata_sr_d;
      rdata_sr_q  <= rdata_sr_d;
      l_addr_q    <= l_addr_d;
      l_wdata_q   <= l_wdata_d;
      l_wen_q     <= l_wen_d;
      l_ren_q     <= l_ren_d;
      acka_q      <= acka_d;
      ackw_q      <= ackw_d;
      rd_active_q <= rd_active_d;
    end
  end

  // Address ACK is withheld when the local side is busy; the master's window then lapses.
  assign bus.B_ACK     = (acka_q & L_READY) | ackw_q;
  assign bus.B_READY   = (state_q == IDLE) & L_READY;
  assign bus.B_BUS_OUT = rd_active_q & bus.B_UTIL & rdata_sr_q[0];

  assign L_ADDR  = l_addr_q;
  assign L_WDATA = l_wdata_q;
  assign L_WEN   = l_wen_q;
  assign L_REN   = l_ren_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// tb/tb_bus_slave_port.sv - directed, table-driven bench for bus_slave_port.
module tb_bus_slave_port;

  typedef struct {
    logic        rw;
    logic        sel;
    logic        lrdy;
    logic [15:0] addr;
    logic [7:0]  data;
    int          rv_dly;
    int          gap_at;
    int          exp_acks;
    int          exp_wen;
    int          exp_ren;
    logic [11:0] exp_laddr;
    logic [7:0]  exp_rbits;
    string       name;
  } vec_t;

  logic        CLK;
  logic        RSTN;
  logic [11:0] L_ADDR;
  logic [7:0]  L_WDATA;
  logic        L_WEN;
  logic        L_REN;
  logic [7:0]  L_RDATA;
  logic        L_RVALID;
  logic        L_READY;

  int checks;
  int errors;
  int ack_cnt, wen_cnt, ren_cnt, bad_out;
  logic [11:0] wen_addr, ren_addr;
  logic [7:0]  wen_data;

  vec_t vecs[11];

  bus_slave_port_if bus ();

  bus_slave_port #(
    .ADDR_W     (12),
    .DATA_W     (8),
    .RD_TIMEOUT (15)
  ) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .bus      (bus.slave),
    .L_ADDR   (L_ADDR),
    .L_WDATA  (L_WDATA),
    .L_WEN    (L_WEN),
    .L_REN    (L_REN),
    .L_RDATA  (L_RDATA),
    .L_RVALID (L_RVALID),
    .L_READY  (L_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    #2;
    if (bus.B_ACK === 1'b1) ack_cnt++;
    if (L_WEN === 1'b1) begin
      wen_cnt++;
      wen_addr = L_ADDR;
      wen_data = L_WDATA;
    end
    if (L_REN === 1'b1) begin
      ren_cnt++;
      ren_addr = L_ADDR;
    end
    if (bus.B_BUS_OUT === 1'b1 && bus.B_UTIL !== 1'b1) bad_out++;
    if (L_WEN === 1'b1 || L_REN === 1'b1) chk("strobe_exclusive", {31'd0, L_WEN & L_REN}, 32'd0);
  end

  task automatic send_addr(input logic [15:0] a, input logic sel, input logic rw);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      bus.B_UTIL   = 1'b1;
      bus.S_SEL    = sel;
      bus.B_RW     = rw;
      bus.B_BUS_IN = a[i];
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] rb;
    logic       gap_out;
    logic       gap_rdy;
    rb      = '0;
    gap_out = 1'b0;
    gap_rdy = 1'b0;
    ack_cnt = 0;
    wen_cnt = 0;
    ren_cnt = 0;
    bad_out = 0;
    send_addr(v.addr, v.sel, v.rw);
    @(negedge CLK);
    bus.B_UTIL   = 1'b0;
    bus.S_SEL    = 1'b0;
    bus.B_BUS_IN = 1'b0;
    L_READY      = v.lrdy;
    if (v.rw) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge CLK);
        L_READY      = 1'b1;
        bus.B_UTIL   = 1'b1;
        bus.B_BUS_IN = v.data[i];
      end
      @(negedge CLK);
      bus.B_UTIL   = 1'b0;
      bus.B_BUS_IN = 1'b0;
      @(negedge CLK);
    end else begin
      @(negedge CLK);
      L_READY = 1'b1;
      for (int k = 1; k <= v.rv_dly; k++) begin
        @(negedge CLK);
        L_RVALID = (k == v.rv_dly);
        L_RDATA  = (k == v.rv_dly) ? v.data : 8'h00;
      end
      for (int i = 0; i < 8; i++) begin
        @(negedge CLK);
        L_RVALID = 1'b0;
        L_RDATA  = 8'h00;
        if (v.gap_at >= 0 && i == v.gap_at + 1) begin
          bus.B_UTIL = 1'b0;
          for (int g = 0; g < 4; g++) begin
            if (g > 0) @(negedge CLK);
            #1;
            gap_out = gap_out | bus.B_BUS_OUT;
            gap_rdy = gap_rdy | bus.B_READY;
          end
          @(negedge CLK);
        end
        bus.B_UTIL = 1'b1;
        #1;
        rb[i] = bus.B_BUS_OUT;
      end
      @(negedge CLK);
      bus.B_UTIL = 1'b0;
    end
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk({v.name, ".acks"}, ack_cnt, v.exp_acks);
    chk({v.name, ".wen"}, wen_cnt, v.exp_wen);
    chk({v.name, ".ren"}, ren_cnt, v.exp_ren);
    chk({v.name, ".bus_out_idle"}, bad_out, 0);
    chk({v.name, ".ready_after"}, {31'd0, bus.B_READY}, 32'd1);
    if (v.exp_wen > 0) begin
      chk({v.name, ".wen_addr"}, {20'd0, wen_addr}, {20'd0, v.exp_laddr});
      chk({v.name, ".wen_data"}, {24'd0, wen_data}, {24'd0, v.data});
    end
    if (v.exp_ren > 0) chk({v.name, ".ren_addr"}, {20'd0, ren_addr}, {20'd0, v.exp_laddr});
    if (!v.rw) chk({v.name, ".rbits"}, {24'd0, rb}, {24'd0, v.exp_rbits});
    if (v.gap_at >= 0) begin
      chk({v.name, ".gap_out"}, {31'd0, gap_out}, 32'd0);
      chk({v.name, ".gap_busy"}, {31'd0, gap_rdy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    ack_cnt      = 0;
    wen_cnt      = 0;
    ren_cnt      = 0;
    bad_out      = 0;
    wen_addr     = '0;
    ren_addr     = '0;
    wen_data     = '0;
    RSTN         = 1'b0;
    L_READY      = 1'b1;
    L_RVALID     = 1'b0;
    L_RDATA      = 8'h00;
    bus.S_SEL    = 1'b0;
    bus.B_UTIL   = 1'b0;
    bus.B_RW     = 1'b0;
    bus.B_BUS_IN = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h0A5C, 8'h3C, 0,  -1, 2, 1, 0, 12'h297, 8'h00, "wr_0A5C"};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 8'hA5, 3,  -1, 1, 0, 1, 12'h004, 8'hA5, "rd_0010"};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 8'hA5, 3,   3, 1, 0, 1, 12'h004, 8'hA5, "rd_gap"};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0A5C, 8'h3C, 0,  -1, 0, 0, 0, 12'h000, 8'h00, "wr_notready"};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h1234, 8'h55, 0,  -1, 0, 0, 0, 12'h000, 8'h00, "wr_nosel"};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0010, 8'hA5, 3,  -1, 0, 0, 0, 12'h000, 8'h00, "rd_nosel"};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h3FFC, 8'h5A, 1,  -1, 1, 0, 1, 12'hFFF, 8'h5A, "rd_3FFC"};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h81, 0,  -1, 2, 1, 0, 12'hFFF, 8'h00, "wr_FFFF"};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0A5C, 8'hC3, 15, -1, 1, 0, 1, 12'h297, 8'hC3, "rd_last_cycle"};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0A5C, 8'hC3, 16, -1, 1, 0, 1, 12'h297, 8'h00, "rd_timeout"};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0004, 8'hFF, 0,  -1, 2, 1, 0, 12'h001, 8'h00, "wr_after_rst"};

    repeat (2) @(negedge CLK);
    #1;
    chk("rst.ready", {31'd0, bus.B_READY}, 32'd1);
    chk("rst.ack", {31'd0, bus.B_ACK}, 32'd0);
    chk("rst.bus_out", {31'd0, bus.B_BUS_OUT}, 32'd0);
    chk("rst.strobes", {30'd0, L_WEN, L_REN}, 32'd0);
    chk("rst.laddr", {20'd0, L_ADDR}, 32'd0);
    chk("rst.lwdata", {24'd0, L_WDATA}, 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    L_READY = 1'b0;
    #1;
    chk("idle_not_lready", {31'd0, bus.B_READY}, 32'd0);
    @(negedge CLK);
    L_READY = 1'b1;

    for (int n = 0; n < 10; n++) run_vec(vecs[n]);

    // Address phase dropped half way returns to IDLE without a strobe.
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      bus.B_UTIL   = 1'b1;
      bus.S_SEL    = 1'b1;
      bus.B_BUS_IN = i[0];
    end
    @(negedge CLK);
    bus.B_UTIL = 1'b0;
    bus.S_SEL  = 1'b0;
    #1;
    chk("addr_abort.busy", {31'd0, bus.B_READY}, 32'd0);
    @(negedge CLK);
    #1;
    chk("addr_abort.ready", {31'd0, bus.B_READY}, 32'd1);
    chk("addr_abort.acks", ack_cnt, 0);

    // Reset during write data bit 5.
    ack_cnt = 0;
    wen_cnt = 0;
    send_addr(16'h0A5C, 1'b1, 1'b1);
    @(negedge CLK);
    bus.B_UTIL = 1'b0;
    bus.S_SEL  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      bus.B_UTIL   = 1'b1;
      bus.B_BUS_IN = vecs[0].data[i];
      if (i == 5) RSTN = 1'b0;
    end
    #1;
    chk("midrst.laddr", {20'd0, L_ADDR}, 32'd0);
    chk("midrst.ready", {31'd0, bus.B_READY}, 32'd1);
    @(negedge CLK);
    bus.B_UTIL = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    #1;
    chk("midrst.wen", wen_cnt, 0);
    chk("midrst.acks", ack_cnt, 1);
    run_vec(vecs[10]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
